elevator_motion_controller: RTL and testbench

Cabin motion and door sequencer for the four-floor elevator, sitting directly downstream of the request memory manager. It consumes the manager's direction (`UDRequest`), door (`OCRequest`) and restart (`NoStopRequest`) commands. It produces the cabin position and status the manager runs on: `CurrentFloor`, `UDIn`, the arrival pulse `Delay` and the idle flag `Stop`. Travel and door dwell are timed by internal counters, replacing the testbench-driven position stimulus.

---
 rtl/elevator_motion_controller.sv | 90 +++++++++
 tb/tb_elevator_motion_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_motion_controller.sv
`timescale 1ns/1ps
// elevator_motion_controller: cabin travel and door sequencer with timed floor and door phases
module elevator_motion_controller #(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       UDRequest,
  input  logic       OCRequest,
  input  logic       NoStopRequest,
  output logic [1:0] CurrentFloor,
  output logic       UDIn,
  output logic       Delay,
  output logic       Stop,
  output logic       DoorOpen,
  output logic       Moving
);
  localparam int TW = $clog2(FLOOR_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  typedef enum logic [1:0] {IDLE, MOVE, ARRIVE, DOOR} state_t;
  state_t state, state_nx;
  logic [TW-1:0] travel_cnt, travel_nx;
  logic [DW-1:0] door_cnt, door_nx;
  logic [1:0] floor_nx;
  logic dir_nx, blocked, start;
  assign blocked = UDRequest ? (CurrentFloor == 2'd3) : (CurrentFloor == 2'd0);
  assign Delay = state == ARRIVE;
  assign Stop = state == IDLE;
  assign DoorOpen = state == DOOR;
  assign Moving = state == MOVE;
  // Next-state, counter and position decisions; start marks any launch into MOVE.
  always_comb begin
    state_nx = state;
    travel_nx = travel_cnt;
    door_nx = door_cnt;
    floor_nx = CurrentFloor;
    dir_nx = UDIn;
    start = 1'b0;
    case (state)
      IDLE: begin
        state_nx = !NoStopRequest ? IDLE : blocked ? ARRIVE : MOVE;
        start = NoStopRequest && !blocked;
      end
      MOVE:
        if (travel_cnt == '0) begin
          floor_nx = UDIn ? CurrentFloor + 2'd1 : CurrentFloor - 2'd1;
          state_nx = ARRIVE;
        end else travel_nx = travel_cnt - TW'(1);
      ARRIVE:
        if (OCRequest) begin
          state_nx = DOOR;
          door_nx = DW'(DOOR_TICKS - 1);
        end else begin
          state_nx = blocked ? IDLE : MOVE;
          start = !blocked;
        end
      DOOR:
        if (door_cnt != '0) door_nx = door_cnt - DW'(1);
        else begin
          state_nx = !NoStopRequest ? IDLE : blocked ? ARRIVE : MOVE;
          start = NoStopRequest && !blocked;
        end
      default: state_nx = IDLE;
    endcase
    if (start) begin
      travel_nx = TW'(FLOOR_TICKS - 1);
      dir_nx = UDRequest;
    end
  end
  // State, counters, floor and direction registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      travel_cnt <= '0;
      door_cnt <= '0;
      CurrentFloor <= 2'd0;
      UDIn <= 1'b0;
    end else begin
      state <= state_nx;
      travel_cnt <= travel_nx;
      door_cnt <= door_nx;
      CurrentFloor <= floor_nx;
      UDIn <= dir_nx;
    end
  // A floor step must never wrap past a terminal floor.
  always_ff @(posedge clk)
    if (rst_n && state == MOVE && travel_cnt == '0)
      assert (UDIn ? CurrentFloor != 2'd3 : CurrentFloor != 2'd0);
endmodule

// File: tb/tb_elevator_motion_controller.sv
`timescale 1ns/1ps
// tb_elevator_motion_controller: directed and random checks against a segment-scheduled cabin model
module tb_elevator_motion_controller;
  localparam int FT = 4;
  localparam int DT = 3;
  localparam logic [1:0] M_IDLE = 2'd0, M_MOVE = 2'd1, M_ARRIVE = 2'd2, M_DOOR = 2'd3;
  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] floor;
    logic       dir;
  } snap_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic UDRequest = 1'b0, OCRequest = 1'b0, NoStopRequest = 1'b0;
  logic [1:0] CurrentFloor;
  logic UDIn, Delay, Stop, DoorOpen, Moving;
  int total = 0, bad = 0;
  snap_t cur;
  snap_t plan[$];
  wire [5:0] dut_vec = {CurrentFloor, UDIn, Delay, Stop, DoorOpen, Moving};

  elevator_motion_controller #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .rst_n(rst_n), .UDRequest(UDRequest), .OCRequest(OCRequest),
    .NoStopRequest(NoStopRequest), .CurrentFloor(CurrentFloor), .UDIn(UDIn),
    .Delay(Delay), .Stop(Stop), .DoorOpen(DoorOpen), .Moving(Moving)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(logic [1:0] m, logic [1:0] f, logic d);
    snap_t s;
    s.mode = m;
    s.floor = f;
    s.dir = d;
    return s;
  endfunction

  function automatic logic blocked(logic up, logic [1:0] f);
    return up ? f == 2'd3 : f == 2'd0;
  endfunction

  function automatic logic [5:0] exp_vec();
    return {cur.floor, cur.dir, cur.mode == M_ARRIVE, cur.mode == M_IDLE, cur.mode == M_DOOR, cur.mode == M_MOVE};
  endfunction

  // A whole trip segment: FT cycles travelling, then one arrival cycle on the next floor.
  task automatic plan_move(input logic up);
    for (int i = 0; i < FT; i++) plan.push_back(mk(M_MOVE, cur.floor, up));
    plan.push_back(mk(M_ARRIVE, up ? cur.floor + 2'd1 : cur.floor - 2'd1, up));
  endtask

  // Drive one cycle of inputs; when no segment is scheduled, decide the next one.
  task automatic step(input logic ud, input logic oc, input logic ns);
    UDRequest = ud;
    OCRequest = oc;
    NoStopRequest = ns;
    if (plan.size() == 0) begin
      case (cur.mode)
        M_IDLE:
          if (ns) begin
            if (blocked(ud, cur.floor)) plan.push_back(mk(M_ARRIVE, cur.floor, cur.dir));
            else plan_move(ud);
          end
        M_ARRIVE:
          if (oc) for (int i = 0; i < DT; i++) plan.push_back(mk(M_DOOR, cur.floor, cur.dir));
          else if (blocked(ud, cur.floor)) plan.push_back(mk(M_IDLE, cur.floor, cur.dir));
          else plan_move(ud);
        M_DOOR:
          if (ns && !blocked(ud, cur.floor)) plan_move(ud);
          else if (ns) plan.push_back(mk(M_ARRIVE, cur.floor, cur.dir));
          else plan.push_back(mk(M_IDLE, cur.floor, cur.dir));
        default: plan.push_back(mk(M_IDLE, cur.floor, cur.dir));
      endcase
    end
    if (plan.size() != 0) cur = plan.pop_front();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    cur = mk(M_IDLE, 2'd0, 1'b0);
    plan.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cur = mk(M_IDLE, 2'd0, 1'b0);
    plan.delete();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dut_vec !== 6'b000100) begin bad++; $display("FAIL reset_state: got %b want %b", dut_vec, 6'b000100); end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b1);
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_premove%0d: got %b want %b", i, dut_vec, exp_vec()); end
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec !== 6'b000100) begin bad++; $display("FAIL reset_async: got %b want %b", dut_vec, 6'b000100); end
    cur = mk(M_IDLE, 2'd0, 1'b0);
    plan.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (dut_vec !== 6'b000100) begin bad++; $display("FAIL reset_hold%0d: got %b want %b", i, dut_vec, 6'b000100); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'(i), 1'b1, 1'b0);
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_release%0d: got %b want %b", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_single_trip();
    int mv = 0, dr = 0, dl = 0;
    for (int i = 0; i < FT + DT + 4; i++) begin
      step(1'b1, 1'b1, i == 0);
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL single_trip_cyc%0d: got %b want %b", i, dut_vec, exp_vec()); end
      if (Moving) mv++;
      if (DoorOpen) dr++;
      if (Delay) dl++;
    end
    total++;
    if (mv != FT) begin bad++; $display("FAIL single_trip_move_cycles: got %0d want %0d", mv, FT); end
    total++;
    if (dr != DT) begin bad++; $display("FAIL single_trip_door_cycles: got %0d want %0d", dr, DT); end
    total++;
    if (dl != 1) begin bad++; $display("FAIL single_trip_delay_pulses: got %0d want 1", dl); end
    total++;
    if (CurrentFloor !== 2'd1 || Stop !== 1'b1) begin bad++; $display("FAIL single_trip_end: got floor=%0d stop=%b want floor=1 stop=1", CurrentFloor, Stop); end
  endtask

  task automatic test_pass_through();
    int np = 0, dr = 0, door_elsewhere = 0;
    int pt[3];
    logic [1:0] pf[3];
    do_reset();
    for (int i = 0; i < 3 * (FT + 1) + DT + 4; i++) begin
      step(1'b1, cur.floor == 2'd3, i == 0);
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL pass_cyc%0d: got %b want %b", i, dut_vec, exp_vec()); end
      if (Delay) begin
        if (np < 3) begin pt[np] = i; pf[np] = CurrentFloor; end
        np++;
      end
      if (DoorOpen) begin
        dr++;
        if (CurrentFloor != 2'd3) door_elsewhere++;
      end
    end
    total++;
    if (np != 3) begin bad++; $display("FAIL pass_pulses: got %0d want 3", np); end
    else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (pf[k] !== 2'(k + 1)) begin bad++; $display("FAIL pass_floor%0d: got %0d want %0d", k, pf[k], k + 1); end
      end
      total++;
      if (pt[1] - pt[0] != FT + 1 || pt[2] - pt[1] != FT + 1) begin
        bad++; $display("FAIL pass_spacing: got %0d,%0d want %0d", pt[1] - pt[0], pt[2] - pt[1], FT + 1);
      end
    end
    total++;
    if (dr != DT || door_elsewhere != 0) begin bad++; $display("FAIL pass_door: got cycles=%0d off_floor=%0d want %0d,0", dr, door_elsewhere, DT); end
  endtask

  task automatic test_boundary();
    step(1'b1, 1'b0, 1'b1);
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL boundary_arrive: got %b want %b", dut_vec, exp_vec()); end
    total++;
    if (Delay !== 1'b1 || CurrentFloor !== 2'd3 || Moving !== 1'b0) begin
      bad++; $display("FAIL boundary_no_move: got delay=%b floor=%0d moving=%b want 1,3,0", Delay, CurrentFloor, Moving);
    end
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL boundary_idle: got %b want %b", dut_vec, exp_vec()); end
    total++;
    if (Stop !== 1'b1 || CurrentFloor !== 2'd3) begin bad++; $display("FAIL boundary_back_idle: got stop=%b floor=%0d want 1,3", Stop, CurrentFloor); end
  endtask

  task automatic test_door_exit();
    int np = 0, mv = 0;
    logic [1:0] pf[2];
    for (int i = 0; i < 2 * (FT + 1 + DT) + 4; i++) begin
      step(1'b0, 1'b1, cur.floor != 2'd1);
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL door_exit_cyc%0d: got %b want %b", i, dut_vec, exp_vec()); end
      if (Delay) begin
        if (np < 2) pf[np] = CurrentFloor;
        np++;
      end
      if (Moving) mv++;
    end
    total++;
    if (np != 2 || pf[0] !== 2'd2 || pf[1] !== 2'd1) begin bad++; $display("FAIL door_exit_arrivals: got n=%0d f0=%0d f1=%0d want 2,2,1", np, pf[0], pf[1]); end
    total++;
    if (mv != 2 * FT) begin bad++; $display("FAIL door_exit_move_cycles: got %0d want %0d", mv, 2 * FT); end
    total++;
    if (Stop !== 1'b1 || CurrentFloor !== 2'd1 || UDIn !== 1'b0) begin
      bad++; $display("FAIL door_exit_end: got stop=%b floor=%0d udin=%b want 1,1,0", Stop, CurrentFloor, UDIn);
    end
  endtask

  task automatic test_ignored_inputs();
    int mv = 0, dr = 0;
    logic ud, oc, ns;
    for (int i = 0; i < FT + DT + 4; i++) begin
      ud = i == 0 ? 1'b1 : 1'($urandom_range(0, 1));
      oc = cur.mode == M_ARRIVE ? 1'b1 : 1'($urandom_range(0, 1));
      ns = i == 0 ? 1'b1 : (cur.mode == M_IDLE || (cur.mode == M_DOOR && plan.size() == 0)) ? 1'b0 : 1'($urandom_range(0, 1));
      step(ud, oc, ns);
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL ignored_cyc%0d: got %b want %b", i, dut_vec, exp_vec()); end
      if (Moving) mv++;
      if (DoorOpen) dr++;
    end
    total++;
    if (mv != FT || dr != DT || CurrentFloor !== 2'd2) begin
      bad++; $display("FAIL ignored_timing: got move=%0d door=%0d floor=%0d want %0d,%0d,2", mv, dr, CurrentFloor, FT, DT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL random_cyc%0d: got %b want %b", i, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_trip();
    test_pass_through();
    test_boundary();
    test_door_exit();
    test_ignored_inputs();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
